// File: rtl/ica_pkg.sv
// ica_pkg: shared types and helpers for the ICA output paths.
//   Y_W / OUT_W / NCH : source width, output sample width, channels per frame
//   frame_t           : NCH packed OUT_W-bit signed samples (index 0 = y1)
//   state_t           : serializer FSM states
//   sat_round()       : round-half-up right shift then saturate to OUT_W bits
package ica_pkg;
  localparam int Y_W   = 26;
  localparam int OUT_W = 16;
  localparam int NCH   = 4;

  typedef logic [NCH-1:0][OUT_W-1:0] frame_t;
  typedef enum logic {IDLE, SEND} state_t;

  localparam logic signed [Y_W:0] SAT_MAX = (Y_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [Y_W:0] SAT_MIN = ~SAT_MAX;

  // One extra bit of headroom so adding the rounding constant to the
  // largest positive input cannot wrap.
  function automatic logic [OUT_W-1:0] sat_round(input logic [Y_W-1:0] y, input int shift);
    logic [Y_W:0]        rnd;
    logic signed [Y_W:0] t;
    logic signed [Y_W:0] r;
    rnd = (Y_W+1)'(1) << (shift - 1);
    t   = $signed({y[Y_W-1], y} + rnd);
    r   = t >>> shift;
    if (r > SAT_MAX)      sat_round = {1'b0, {(OUT_W-1){1'b1}}};
    else if (r < SAT_MIN) sat_round = {1'b1, {(OUT_W-1){1'b0}}};
    else                  sat_round = r[OUT_W-1:0];
  endfunction
endpackage

// File: rtl/ica_frame_fifo.sv
// ica_frame_fifo: synchronous FIFO of whole frames.
//   clk, rst   : clock, synchronous active-high reset (pointers/level only)
//   push, din  : write a frame (caller guarantees not full unless popping)
//   pop, dout  : dout is the head frame, valid combinationally while level>0
//   level      : frames stored, 0..DEPTH
module ica_frame_fifo import ica_pkg::*; #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  frame_t                 din,
  input  logic                   pop,
  output frame_t                 dout,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  frame_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;

  // DEPTH is a power of 2, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign dout = mem[rd_ptr];
endmodule

// File: rtl/ica_output_serializer.sv
// ica_output_serializer: captures FastICA frames (y1..y4), rounds/saturates
// each channel to 16 bits, buffers frames, and streams one channel per cycle.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid, y1..y4      : one-cycle frame strobe and 26-bit signed sources
//   out_valid/out_ready   : output handshake
//   out_data/chan/last    : sample, channel 0..3, last on channel 3
//   level                 : frames in the FIFO (not counting the one being sent)
//   drop_count            : frames lost to a full FIFO, saturating
module ica_output_serializer import ica_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int SHIFT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [Y_W-1:0]         y1,
  input  logic [Y_W-1:0]         y2,
  input  logic [Y_W-1:0]         y3,
  input  logic [Y_W-1:0]         y4,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic [1:0]             out_chan,
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            drop_count
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [NCH-1:0][Y_W-1:0] y_in;
  frame_t                  conv;
  frame_t                  s1_frame;
  logic                    s1_valid;

  assign y_in = {y4, y3, y2, y1};

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    assign conv[c] = sat_round(y_in[c], SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_frame <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) s1_frame <= conv;
    end
  end

  // FIFO and push/drop decision
  frame_t fifo_dout;
  logic   push, pop, drop, nonempty, full;

  assign nonempty = level != '0;
  assign full     = level == LW'(DEPTH);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push     = s1_valid && (!full || pop);
  assign drop     = s1_valid && !push;

  ica_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (s1_frame),
    .pop   (pop),
    .dout  (fifo_dout),
    .level (level)
  );

  always_ff @(posedge clk) begin
    if (rst)                                drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end

  // Send FSM
  state_t     state, state_d;
  logic [1:0] chan, chan_d;
  frame_t     send_frame, frame_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      chan       <= '0;
      send_frame <= '0;
    end else begin
      state      <= state_d;
      chan       <= chan_d;
      send_frame <= frame_d;
    end
  end

  always_comb begin
    state_d = state;
    chan_d  = chan;
    frame_d = send_frame;
    pop     = 1'b0;
    case (state)
      IDLE: if (nonempty) begin
        pop     = 1'b1;
        frame_d = fifo_dout;
        chan_d  = '0;
        state_d = SEND;
      end
      SEND: if (out_ready) begin
        if (chan != 2'd3) begin
          chan_d = chan + 2'd1;
        end else if (nonempty) begin
          // Reload straight from the FIFO head: no bubble between frames.
          pop     = 1'b1;
          frame_d = fifo_dout;
          chan_d  = '0;
        end else begin
          chan_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = state == SEND;
  assign out_chan  = chan;
  assign out_last  = out_valid && chan == 2'd3;
  assign out_data  = out_valid ? send_frame[chan] : '0;
endmodule

// File: tb/tb_ica_output_serializer.sv
module tb_ica_output_serializer;
  localparam int DEPTH = 16;
  localparam int SHIFT = 8;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [25:0] y1, y2, y3, y4;
  logic        out_valid, out_last;
  logic [15:0] out_data, drop_count;
  logic [1:0]  out_chan;
  logic [4:0]  level;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  chan;
    logic        last;
  } word_t;

  word_t q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ica_output_serializer #(.DEPTH(DEPTH), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .y1(y1), .y2(y2), .y3(y3), .y4(y4),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .out_last(out_last), .level(level), .drop_count(drop_count)
  );

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Reference: integer floor((y + 2^(S-1)) / 2^S), clamped to int16.
  function automatic logic [15:0] model(input logic [25:0] y);
    longint t, r;
    t = longint'($signed(y)) + (longint'(1) << (SHIFT - 1));
    r = t >>> SHIFT;
    if (r > 32767)  return 16'h7FFF;
    if (r < -32768) return 16'h8000;
    return 16'(r);
  endfunction

  task automatic drive(input logic [25:0] a, b, c, d, input bit keep);
    logic [25:0] ys [4];
    ys = '{a, b, c, d};
    y1 = a; y2 = b; y3 = c; y4 = d;
    in_valid = 1'b1;
    if (keep)
      for (int ch = 0; ch < 4; ch++) q.push_back('{model(ys[ch]), 2'(ch), ch == 3});
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    y1 = '0; y2 = '0; y3 = '0; y4 = '0;
    repeat (3) tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 16'd0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
    checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL reset_chan got %0d want 0", out_chan); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", out_last); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_count); end
    rst = 1'b0;
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_post_valid got %b want 0", out_valid); end
  endtask

  task automatic test_round;
    int cnt, got, cyc;
    word_t w;
    out_ready = 1'b1;
    drive(26'd256, 26'd128, 26'd127, -26'sd129, 1'b0);
    q.push_back('{16'd1, 2'd0, 1'b0});
    q.push_back('{16'd1, 2'd1, 1'b0});
    q.push_back('{16'd0, 2'd2, 1'b0});
    q.push_back('{16'hFFFF, 2'd3, 1'b1});
    tick; in_valid = 1'b0; cnt = 1;
    while (!out_valid && cnt < 20) begin tick; cnt++; end
    checks++; if (cnt != 3) begin errors++; $display("FAIL round_latency got %0d want 3", cnt); end
    got = 0; cyc = 0;
    while (got < 4 && cyc < 50) begin
      if (out_valid && out_ready) begin
        if (q.size() != 0) w = q.pop_front(); else w = 'x;
        checks++;
        if ({out_data, out_chan, out_last} !== w) begin
          errors++; $display("FAIL round_word%0d got %h/%0d/%b want %h/%0d/%b", got, out_data, out_chan, out_last, w.data, w.chan, w.last);
        end
        got++;
      end
      tick; cyc++;
    end
    checks++; if (got != 4) begin errors++; $display("FAIL round_timeout got %0d words want 4", got); end
  endtask

  task automatic test_saturation;
    int got, cyc;
    word_t w;
    out_ready = 1'b1;
    drive(26'h1FFFFFF, 26'h2000000, 26'd8388352, 26'(-8388609), 1'b0);
    q.push_back('{16'h7FFF, 2'd0, 1'b0});
    q.push_back('{16'h8000, 2'd1, 1'b0});
    q.push_back('{16'h7FFF, 2'd2, 1'b0});
    q.push_back('{16'h8000, 2'd3, 1'b1});
    tick; in_valid = 1'b0;
    got = 0; cyc = 0;
    while (got < 4 && cyc < 50) begin
      if (out_valid && out_ready) begin
        if (q.size() != 0) w = q.pop_front(); else w = 'x;
        checks++;
        if ({out_data, out_chan, out_last} !== w) begin
          errors++; $display("FAIL sat_word%0d got %h/%0d/%b want %h/%0d/%b", got, out_data, out_chan, out_last, w.data, w.chan, w.last);
        end
        got++;
      end
      tick; cyc++;
    end
    checks++; if (got != 4) begin errors++; $display("FAIL sat_timeout got %0d words want 4", got); end
  endtask

  task automatic test_back_to_back;
    int got, cyc, gaps, peak;
    bit seen;
    word_t w;
    out_ready = 1'b1;
    got = 0; cyc = 0; gaps = 0; peak = 0; seen = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          drive(26'($urandom), 26'($urandom), 26'($urandom), 26'($urandom), 1'b1);
          tick;
        end
        in_valid = 1'b0;
      end
      begin
        while (got < 20 && cyc < 100) begin
          if (int'(level) > peak) peak = int'(level);
          if (seen && !out_valid) gaps++;
          if (out_valid) seen = 1'b1;
          if (out_valid && out_ready) begin
            if (q.size() != 0) w = q.pop_front(); else w = 'x;
            checks++;
            if ({out_data, out_chan, out_last} !== w) begin
              errors++; $display("FAIL b2b_word%0d got %h/%0d/%b want %h/%0d/%b", got, out_data, out_chan, out_last, w.data, w.chan, w.last);
            end
            got++;
          end
          tick; cyc++;
        end
      end
    join
    checks++; if (got != 20) begin errors++; $display("FAIL b2b_timeout got %0d words want 20", got); end
    checks++; if (gaps != 0) begin errors++; $display("FAIL b2b_gaps got %0d want 0", gaps); end
    checks++; if (peak == 0) begin errors++; $display("FAIL b2b_peak got %0d want >0", peak); end
    repeat (2) tick;
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL b2b_level got %0d want 0", level); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL b2b_drop got %0d want 0", drop_count); end
  endtask

  task automatic test_overflow;
    int got, cyc;
    word_t w;
    out_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      drive(26'($urandom), 26'($urandom), 26'($urandom), 26'($urandom), i < 17);
      tick;
    end
    in_valid = 1'b0;
    repeat (4) tick;
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d want 16", level); end
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL ovf_drop got %0d want 1", drop_count); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %b want 1", out_valid); end
    out_ready = 1'b1;
    got = 0; cyc = 0;
    while (got < 68 && cyc < 200) begin
      if (out_valid && out_ready) begin
        if (q.size() != 0) w = q.pop_front(); else w = 'x;
        checks++;
        if ({out_data, out_chan, out_last} !== w) begin
          errors++; $display("FAIL ovf_word%0d got %h/%0d/%b want %h/%0d/%b", got, out_data, out_chan, out_last, w.data, w.chan, w.last);
        end
        got++;
      end
      tick; cyc++;
    end
    checks++; if (got != 68) begin errors++; $display("FAIL ovf_timeout got %0d words want 68", got); end
    repeat (3) tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_extra_frame got valid %b want 0", out_valid); end
  endtask

  task automatic test_backpressure;
    int got, cyc;
    bit stalled;
    logic [18:0] prev;
    word_t w;
    got = 0; cyc = 0; stalled = 1'b0; prev = '0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          drive(26'($urandom), 26'($urandom), 26'($urandom), 26'($urandom), 1'b1);
          tick;
          in_valid = 1'b0;
          repeat ($urandom_range(0, 3)) tick;
        end
      end
      begin
        while (got < 40 && cyc < 2000) begin
          out_ready = ($urandom_range(0, 99) < 30);
          if (stalled) begin
            checks++;
            if ({out_valid, out_data, out_chan, out_last} !== {1'b1, prev}) begin
              errors++; $display("FAIL bp_stable got %b/%h/%0d want 1/%h/%0d", out_valid, out_data, out_chan, prev[18:3], prev[2:1]);
            end
          end
          if (out_valid && out_ready) begin
            if (q.size() != 0) w = q.pop_front(); else w = 'x;
            checks++;
            if ({out_data, out_chan, out_last} !== w) begin
              errors++; $display("FAIL bp_word%0d got %h/%0d/%b want %h/%0d/%b", got, out_data, out_chan, out_last, w.data, w.chan, w.last);
            end
            got++;
          end
          stalled = out_valid && !out_ready;
          prev = {out_data, out_chan, out_last};
          tick; cyc++;
        end
      end
    join
    out_ready = 1'b1;
    checks++; if (got != 40) begin errors++; $display("FAIL bp_timeout got %0d words want 40", got); end
  endtask

  task automatic test_reset_mid;
    int cnt, got, cyc;
    word_t w;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(26'($urandom), 26'($urandom), 26'($urandom), 26'($urandom), 1'b1);
      tick;
    end
    in_valid = 1'b0;
    repeat (4) tick;
    checks++; if (level !== 5'd3) begin errors++; $display("FAIL rmid_level_pre got %0d want 3", level); end
    out_ready = 1'b1;
    repeat (2) tick;
    out_ready = 1'b0;
    checks++; if (out_chan !== 2'd2) begin errors++; $display("FAIL rmid_chan_pre got %0d want 2", out_chan); end
    rst = 1'b1;
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", out_valid); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL rmid_level got %0d want 0", level); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL rmid_drop got %0d want 0", drop_count); end
    q.delete();
    rst = 1'b0;
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_post_valid got %b want 0", out_valid); end
    out_ready = 1'b1;
    drive(26'($urandom), 26'($urandom), 26'($urandom), 26'($urandom), 1'b1);
    tick; in_valid = 1'b0; cnt = 1;
    while (!out_valid && cnt < 20) begin tick; cnt++; end
    checks++; if (cnt != 3) begin errors++; $display("FAIL rmid_latency got %0d want 3", cnt); end
    got = 0; cyc = 0;
    while (got < 4 && cyc < 50) begin
      if (out_valid && out_ready) begin
        if (q.size() != 0) w = q.pop_front(); else w = 'x;
        checks++;
        if ({out_data, out_chan, out_last} !== w) begin
          errors++; $display("FAIL rmid_word%0d got %h/%0d/%b want %h/%0d/%b", got, out_data, out_chan, out_last, w.data, w.chan, w.last);
        end
        got++;
      end
      tick; cyc++;
    end
    checks++; if (got != 4) begin errors++; $display("FAIL rmid_timeout got %0d words want 4", got); end
  endtask

  initial begin
    test_reset;
    test_round;
    test_saturation;
    test_back_to_back;
    test_overflow;
    test_backpressure;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
